axi_lite_master_bridge: RTL

Single-outstanding AXI4-Lite master that converts a simple request/done command port into AXI-Lite read or write transactions. It sits directly upstream of the timer AXI-Lite slave core and drives its AW/W/B/AR/R channels. Typical traffic is writes of start/clear control bits to 0x0200_4008 and reads of the counter halves at 0x0200_4000/0x0200_4004. It adds a per-transaction timeout so a stalled slave cannot hang the command side.

---
 rtl/axi_lite_master_bridge.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_master_bridge.sv
`default_nettype none
// ============================================================================
// Module  : axi_lite_master_bridge
// Brief   : Single-outstanding AXI4-Lite master driven by a req/done command
//           port, with a per-transaction timeout abort.
// Revision: 1.0 - initial release
// ============================================================================
module axi_lite_master_bridge #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int TRANS_W_STRB_W  = 4,
    parameter int TRANS_WR_RESP_W = 2,
    parameter int TRANS_PROT      = 3,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       i_req,
    input  logic                       i_we,
    input  logic [ADDR_WIDTH-1:0]      i_addr,
    input  logic [DATA_WIDTH-1:0]      i_wdata,
    input  logic [TRANS_W_STRB_W-1:0]  i_wstrb,
    input  logic [TRANS_PROT-1:0]      i_prot,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [DATA_WIDTH-1:0]      o_rdata,
    output logic [TRANS_WR_RESP_W-1:0] o_resp,
    output logic                       o_err,
    output logic                       o_timeout,
    output logic [ADDR_WIDTH-1:0]      o_axi_awaddr,
    output logic [TRANS_PROT-1:0]      o_axi_awprot,
    output logic                       o_axi_awvalid,
    input  logic                       i_axi_awready,
    output logic [DATA_WIDTH-1:0]      o_axi_wdata,
    output logic [TRANS_W_STRB_W-1:0]  o_axi_wstrb,
    output logic                       o_axi_wvalid,
    input  logic                       i_axi_wready,
    input  logic [TRANS_WR_RESP_W-1:0] i_axi_bresp,
    input  logic                       i_axi_bvalid,
    output logic                       o_axi_bready,
    output logic [ADDR_WIDTH-1:0]      o_axi_araddr,
    output logic [TRANS_PROT-1:0]      o_axi_arprot,
    output logic                       o_axi_arvalid,
    input  logic                       i_axi_arready,
    input  logic [DATA_WIDTH-1:0]      i_axi_rdata,
    input  logic [TRANS_WR_RESP_W-1:0] i_axi_rresp,
    input  logic                       i_axi_rvalid,
    output logic                       o_axi_rready
);

    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    // The accept edge is the first counted cycle, so the abort lands on the
    // edge that makes o_done appear exactly TIMEOUT_CYCLES cycles after accept.
    localparam logic [c_CNT_W-1:0] c_ABORT_CNT = c_CNT_W'(TIMEOUT_CYCLES - 2);
    localparam logic [TRANS_WR_RESP_W-1:0] c_RESP_SLVERR = TRANS_WR_RESP_W'(2);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4
    } state_t;

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_aw_done;
    logic                 r_w_done;

    logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic w_final_hs, w_abort;

    assign w_aw_hs    = o_axi_awvalid & i_axi_awready;
    assign w_w_hs     = o_axi_wvalid  & i_axi_wready;
    assign w_b_hs     = o_axi_bready  & i_axi_bvalid;
    assign w_ar_hs    = o_axi_arvalid & i_axi_arready;
    assign w_r_hs     = o_axi_rready  & i_axi_rvalid;
    // A response handshake on the expiry edge still completes normally.
    assign w_final_hs = ((r_state == S_WR_RESP) & w_b_hs) | ((r_state == S_RD_DATA) & w_r_hs);
    assign w_abort    = (r_state != S_IDLE) & (r_cnt == c_ABORT_CNT) & ~w_final_hs;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_aw_done     <= 1'b0;
            r_w_done      <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_rdata       <= '0;
            o_resp        <= '0;
            o_err         <= 1'b0;
            o_timeout     <= 1'b0;
            o_axi_awaddr  <= '0;
            o_axi_awprot  <= '0;
            o_axi_awvalid <= 1'b0;
            o_axi_wdata   <= '0;
            o_axi_wstrb   <= '0;
            o_axi_wvalid  <= 1'b0;
            o_axi_bready  <= 1'b0;
            o_axi_araddr  <= '0;
            o_axi_arprot  <= '0;
            o_axi_arvalid <= 1'b0;
            o_axi_rready  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
            if (w_abort) begin
                r_state       <= S_IDLE;
                o_busy        <= 1'b0;
                o_done        <= 1'b1;
                o_timeout     <= 1'b1;
                o_resp        <= c_RESP_SLVERR;
                o_err         <= 1'b1;
                o_rdata       <= '0;
                o_axi_awvalid <= 1'b0;
                o_axi_wvalid  <= 1'b0;
                o_axi_bready  <= 1'b0;
                o_axi_arvalid <= 1'b0;
                o_axi_rready  <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_req) begin
                            r_cnt        <= '0;
                            r_aw_done    <= 1'b0;
                            r_w_done     <= 1'b0;
                            o_busy       <= 1'b1;
                            o_axi_awaddr <= i_addr;
                            o_axi_awprot <= i_prot;
                            o_axi_wdata  <= i_wdata;
                            o_axi_wstrb  <= i_wstrb;
                            o_axi_araddr <= i_addr;
                            o_axi_arprot <= i_prot;
                            if (i_we) begin
                                r_state       <= S_WR_REQ;
                                o_axi_awvalid <= 1'b1;
                                o_axi_wvalid  <= 1'b1;
                            end else begin
                                r_state       <= S_RD_ADDR;
                                o_axi_arvalid <= 1'b1;
                            end
                        end
                    end
                    S_WR_REQ: begin
                        if (w_aw_hs) begin
                            o_axi_awvalid <= 1'b0;
                            r_aw_done     <= 1'b1;
                        end
                        if (w_w_hs) begin
                            o_axi_wvalid <= 1'b0;
                            r_w_done     <= 1'b1;
                        end
                        if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
                            r_state <= S_WR_RESP;
                        end
                    end
                    S_WR_RESP: begin
                        if (w_b_hs) begin
                            r_state      <= S_IDLE;
                            o_axi_bready <= 1'b0;
                            o_busy       <= 1'b0;
                            o_done       <= 1'b1;
                            o_timeout    <= 1'b0;
                            o_resp       <= i_axi_bresp;
                            o_err        <= (i_axi_bresp != '0);
                            o_rdata      <= '0;
                        end else begin
                            o_axi_bready <= 1'b1;
                        end
                    end
                    S_RD_ADDR: begin
                        if (w_ar_hs) begin
                            o_axi_arvalid <= 1'b0;
                            r_state       <= S_RD_DATA;
                        end
                    end
                    S_RD_DATA: begin
                        if (w_r_hs) begin
                            r_state      <= S_IDLE;
                            o_axi_rready <= 1'b0;
                            o_busy       <= 1'b0;
                            o_done       <= 1'b1;
                            o_timeout    <= 1'b0;
                            o_resp       <= i_axi_rresp;
                            o_err        <= (i_axi_rresp != '0);
                            o_rdata      <= i_axi_rdata;
                        end else begin
                            o_axi_rready <= 1'b1;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
